// File: rtl/demux_1to4_stream_pkg.sv
// demux_1to4_stream_pkg: channel count and channel-index type shared by the 1:4 stream demux files
package demux_1to4_stream_pkg;
  localparam int CH_NUM = 4;
  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/demux_1to4_stream_if.sv
// demux_1to4_stream_if: producer stream (in_*), four consumer streams (out_*), counter clear and counters; slave = demux side, master = environment side
interface demux_1to4_stream_if #(
  parameter int W  = 8,
  parameter int CW = 8
);
  import demux_1to4_stream_pkg::*;
  logic [W-1:0]         in_data;
  ch_idx_t              in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [CH_NUM*W-1:0]  out_data;
  logic [CH_NUM-1:0]    out_valid;
  logic [CH_NUM-1:0]    out_ready;
  logic                 cnt_clr;
  logic [CH_NUM*CW-1:0] xfer_cnt;
  modport slave (
    input  in_data, in_sel, in_valid, out_ready, cnt_clr,
    output in_ready, out_data, out_valid, xfer_cnt
  );
  modport master (
    output in_data, in_sel, in_valid, out_ready, cnt_clr,
    input  in_ready, out_data, out_valid, xfer_cnt
  );
endinterface

// File: rtl/demux_1to2_stage.sv
// demux_1to2_stage: one-entry registered 1:2 split on up_dest carrying W data + EXTRA sideband bits; up_* in, dn_*[0/1] out, each side keeps its last word
module demux_1to2_stage #(
  parameter int W     = 8,
  parameter int EXTRA = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [W+EXTRA-1:0]        up_data,
  input  logic                      up_dest,
  input  logic                      up_valid,
  output logic                      up_ready,
  output logic [1:0][W+EXTRA-1:0]   dn_data,
  output logic [1:0]                dn_valid,
  input  logic [1:0]                dn_ready
);
  localparam int DW = W + EXTRA;
  logic [1:0][DW-1:0] data_q, data_d;
  logic               dest_q, dest_d;
  logic               full_q, full_d;
  logic               run_q, run_d;
  logic               acc;
  always_comb begin
    run_d    = 1'b1;
    up_ready = run_q && (!full_q || dn_ready[dest_q]);
    acc      = up_valid && up_ready;
    full_d   = acc || (full_q && !dn_ready[dest_q]);
    dest_d   = acc ? up_dest : dest_q;
    data_d[0] = (acc && !up_dest) ? up_data : data_q[0];
    data_d[1] = (acc &&  up_dest) ? up_data : data_q[1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      dest_q <= 1'b0;
      full_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      dest_q <= dest_d;
      full_q <= full_d;
      run_q  <= run_d;
    end
  end
  assign dn_valid = {full_q && dest_q, full_q && !dest_q};
  assign dn_data  = data_q;
endmodule

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream: registered 1:4 stream demux (clk, async rst_n, bus.slave: in_* stream routed by in_sel to out_*[k], per-channel xfer_cnt with cnt_clr)
module demux_1to4_stream
  import demux_1to4_stream_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input logic               clk,
  input logic               rst_n,
  demux_1to4_stream_if.slave bus
);
  logic [1:0][W:0]            a_dn_data;
  logic [1:0]                 a_dn_valid, a_dn_ready;
  logic [1:0][1:0][W-1:0]     b_data;
  logic [1:0][1:0]            b_valid;
  logic [CH_NUM-1:0][CW-1:0]  cnt_q, cnt_d;
  demux_1to2_stage #(.W(W), .EXTRA(1)) u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .up_data  ({bus.in_sel[0], bus.in_data}),
    .up_dest  (bus.in_sel[1]),
    .up_valid (bus.in_valid),
    .up_ready (bus.in_ready),
    .dn_data  (a_dn_data),
    .dn_valid (a_dn_valid),
    .dn_ready (a_dn_ready)
  );
  for (genvar g = 0; g < 2; g++) begin : g_b
    demux_1to2_stage #(.W(W), .EXTRA(0)) u_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_data  (a_dn_data[g][W-1:0]),
      .up_dest  (a_dn_data[g][W]),
      .up_valid (a_dn_valid[g]),
      .up_ready (a_dn_ready[g]),
      .dn_data  (b_data[g]),
      .dn_valid (b_valid[g]),
      .dn_ready (bus.out_ready[2*g +: 2])
    );
  end
  assign bus.out_data  = b_data;
  assign bus.out_valid = b_valid;
  always_comb begin
    for (int k = 0; k < CH_NUM; k++)
      cnt_d[k] = bus.cnt_clr ? '0 : cnt_q[k] + CW'(bus.out_valid[k] && bus.out_ready[k]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign bus.xfer_cnt = cnt_q;
endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb_demux_1to4_stream: directed vector table plus scoreboarded sequences for the 1:4 stream demux
module tb_demux_1to4_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  demux_1to4_stream_if #(.W(8), .CW(8)) bus ();
  demux_1to4_stream #(.W(8), .CW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic [3:0]  ordy;
    logic        rdy;
    logic [3:0]  ov;
    logic [31:0] od;
    logic [31:0] cnt;
  } vec_t;
  int checks = 0;
  int failures = 0;
  logic [7:0]  q[4][$];
  logic [7:0]  cnt_m[4];
  logic [3:0]  prev_stall;
  logic [31:0] prev_od;
  vec_t        tv[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask
  task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] ordy, input logic clr);
    bus.in_valid  = iv;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.cnt_clr   = clr;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      cnt_m[k] = 8'd0;
    end
    prev_stall = 4'd0;
    prev_od = 32'd0;
  endtask
  task automatic sb();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cnt%0d", k), {24'd0, bus.xfer_cnt[k*8 +: 8]}, {24'd0, cnt_m[k]});
      if (prev_stall[k])
        chk($sformatf("stable%0d", k), {24'd0, bus.out_data[k*8 +: 8]}, {24'd0, prev_od[k*8 +: 8]});
      if (bus.out_valid[k] && bus.out_ready[k]) begin
        if (q[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious ch%0d got=%h want=none", k, bus.out_data[k*8 +: 8]);
        end else begin
          chk($sformatf("data%0d", k), {24'd0, bus.out_data[k*8 +: 8]}, {24'd0, q[k].pop_front()});
        end
        cnt_m[k] = bus.cnt_clr ? 8'd0 : cnt_m[k] + 8'd1;
      end else if (bus.cnt_clr) begin
        cnt_m[k] = 8'd0;
      end
    end
    prev_stall = bus.out_valid & ~bus.out_ready;
    prev_od = bus.out_data;
    if (bus.in_valid && bus.in_ready) q[bus.in_sel].push_back(bus.in_data);
  endtask
  initial begin
    int first, last, seen, idx;
    logic held, pv;
    logic [1:0] ps;
    logic [7:0] pd;
    logic [1:0] wsel[4];
    logic [7:0] wdat[4];
    tv[0] = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};
    tv[1] = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0000, 32'h00000000, 32'h00000000};
    tv[2] = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 32'h00000000};
    tv[3] = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 32'h00000001};
    tv[4] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 32'h00000101};
    tv[5] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 32'h00010101};
    tv[6] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0, 32'h01010101};
    model_reset();
    drive(1'b0, 2'd0, 8'd0, 4'h0, 1'b0);
    tick();
    tick();
    chk("rst_ov", {28'd0, bus.out_valid}, 32'd0);
    chk("rst_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_cnt", bus.xfer_cnt, 32'd0);
    chk("rst_od", bus.out_data, 32'd0);
    rst_n = 1'b1;
    tick();
    drive(1'b0, 2'd0, 8'd0, 4'hF, 1'b0);
    chk("rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      drive(tv[i].iv, tv[i].sel, tv[i].d, tv[i].ordy, 1'b0);
      chk($sformatf("tv%0d_rdy", i), {31'd0, bus.in_ready}, {31'd0, tv[i].rdy});
      chk($sformatf("tv%0d_ov", i), {28'd0, bus.out_valid}, {28'd0, tv[i].ov});
      chk($sformatf("tv%0d_od", i), bus.out_data, tv[i].od);
      chk($sformatf("tv%0d_cnt", i), bus.xfer_cnt, tv[i].cnt);
      sb();
      tick();
    end
    drive(1'b0, 2'd0, 8'd0, 4'hF, 1'b1);
    sb();
    tick();
    first = -1; last = -1; seen = 0;
    for (int c = 0; c < 20; c++) begin
      drive(c < 16, 2'd2, 8'(8'h10 + c), 4'hF, 1'b0);
      if (c < 16) chk("stream_rdy", {31'd0, bus.in_ready}, 32'd1);
      if (bus.out_valid[2]) begin
        seen++;
        if (first < 0) first = c;
        last = c;
      end
      sb();
      tick();
    end
    chk("stream_seen", seen, 16);
    chk("stream_first", first, 2);
    chk("stream_span", last - first, 15);
    chk("stream_cnt2", {24'd0, bus.xfer_cnt[23:16]}, 32'd16);
    wsel = '{2'd1, 2'd1, 2'd1, 2'd3};
    wdat = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (idx < 4) drive(1'b1, wsel[idx], wdat[idx], (c < 8) ? 4'b1101 : 4'hF, 1'b0);
      else         drive(1'b0, 2'd0, 8'd0, 4'hF, 1'b0);
      if (c == 1) chk("bp_rdy_w2", {31'd0, bus.in_ready}, 32'd1);
      if (c >= 2 && c < 8) chk("bp_rdy_low", {31'd0, bus.in_ready}, 32'd0);
      if (c >= 2 && c < 8) chk("bp_ch1_hold", {24'd0, bus.out_data[15:8]}, 32'hB0);
      if (c < 8) chk("bp_ch3_quiet", {31'd0, bus.out_valid[3]}, 32'd0);
      if (idx < 4 && bus.in_ready) idx++;
      sb();
      tick();
    end
    chk("bp_sent", idx, 4);
    chk("bp_q1_empty", q[1].size(), 0);
    chk("bp_q3_empty", q[3].size(), 0);
    drive(1'b0, 2'd0, 8'd0, 4'hF, 1'b1);
    sb();
    tick();
    for (int c = 0; c < 260; c++) begin
      drive(c < 256, 2'd0, 8'(c), 4'hF, 1'b0);
      sb();
      tick();
    end
    chk("wrap_cnt0", {24'd0, bus.xfer_cnt[7:0]}, 32'd0);
    chk("wrap_q0_empty", q[0].size(), 0);
    for (int c = 0; c < 4; c++) begin
      drive(c == 0, 2'd0, 8'hC1, 4'hF, 1'b0);
      sb();
      tick();
    end
    chk("one_cnt0", {24'd0, bus.xfer_cnt[7:0]}, 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 2'd0, 8'hC2, 4'hF, 1'b0);
      if (bus.out_valid[0]) begin
        bus.cnt_clr = 1'b1;
        seen++;
      end
      sb();
      tick();
    end
    chk("clr_hit", seen, 1);
    chk("clr_cnt0", {24'd0, bus.xfer_cnt[7:0]}, 32'd0);
    held = 1'b0; pv = 1'b0; ps = 2'd0; pd = 8'd0;
    for (int c = 0; c < 10000; c++) begin
      if (!held) begin
        pv = 1'($urandom);
        ps = 2'($urandom);
        pd = 8'($urandom);
      end
      drive(pv, ps, pd, 4'($urandom), ($urandom_range(0, 63) == 0));
      held = pv && !bus.in_ready;
      sb();
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 2'd0, 8'd0, 4'hF, 1'b0);
      sb();
      tick();
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rand_q%0d_empty", k), q[k].size(), 0);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'(c), 8'h50 + 8'(c), 4'h0, 1'b0);
      sb();
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ov", {28'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("mid_rst_cnt", bus.xfer_cnt, 32'd0);
    chk("mid_rst_od", bus.out_data, 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 8'd0, 4'hF, 1'b0);
    tick();
    drive(1'b0, 2'd0, 8'd0, 4'hF, 1'b0);
    chk("mid_rel_rdy", {31'd0, bus.in_ready}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      drive(c == 0, 2'd2, 8'h77, 4'hF, 1'b0);
      sb();
      tick();
    end
    chk("post_rst_q2_empty", q[2].size(), 0);
    chk("post_rst_cnt", bus.xfer_cnt, 32'h00010000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
